// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main-control FSM.
// MC_CTRL_ADDI_EN (optional addi support) is consumed by mc_ctrl_fsm.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_EXEC     = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDIEXEC = 4'd11,
        S_ADDIWB   = 4'd12
    } mc_state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } mc_ctrl_t;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_mem_state(input mc_state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Pure Moore decode: registered FSM state -> raw control vector.
// FETCH's ir_write/pc_write are qualified by mem_ready in the top.
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  mc_state_e state_i,
    output mc_ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main-control FSM with memory-wait watchdog.
// Define MC_CTRL_ADDI_EN to decode addi (001000) instead of flagging it illegal.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic       mem_timeout,
    output mc_state_e  dbg_state_o
);

    localparam int CW        = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam int WAIT_LAST = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;

    mc_state_e state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic timeout_q, timeout_d;
    logic illegal;
    logic mem_stall;
    logic wait_hit;
    mc_ctrl_t ctrl;

    // Handshake: a request (mem_read/mem_write) is held every cycle of a memory
    // state; the transfer completes in the cycle mem_ready=1, and the FSM leaves
    // the state on that edge. mem_ready in any other state is ignored.
    always_comb begin
        state_d   = state_q;
        illegal   = 1'b0;
        mem_stall = is_mem_state(state_q) && !mem_ready;
        wait_hit  = mem_stall && (MEM_WAIT_MAX != 0) && (wait_q == CW'(WAIT_LAST));

        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEXEC;
`else
                    OP_ADDI: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase

        // A stuck memory aborts the instruction; software must re-assert run.
        if (wait_hit) state_d = S_IDLE;

        if (mem_stall && !wait_hit) begin
            wait_d = (wait_q == '1) ? wait_q : wait_q + CW'(1);
        end else begin
            wait_d = '0;
        end
        timeout_d = timeout_q || wait_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    mc_ctrl_out_decode u_out_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign pc_en       = (ctrl.pc_write && ((state_q != S_FETCH) || mem_ready))
                       || (ctrl.pc_write_cond && zero);
    assign ir_write    = ctrl.ir_write && mem_ready;
    assign iord        = ctrl.iord;
    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;
    assign reg_dst     = ctrl.reg_dst;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign reg_write   = ctrl.reg_write;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_op      = ctrl.alu_op;
    assign pc_src      = ctrl.pc_src;
    assign illegal_op  = illegal;
    assign mem_timeout = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction cycle scripts built from
// the instruction-level behaviour, randomized opcodes, waits, zero and run.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, illegal_op, mem_timeout;
    logic [1:0] alu_src_b, alu_op, pc_src;
    mc_state_e  dbg_state;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .dbg_state_o (dbg_state)
    );

    logic [15:0] obs;
    assign obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

    int checks = 0;
    int failures = 0;
    bit exp_to = 1'b0;

    // Scoreboard: one entry per clock cycle of the scripted instruction stream.
    logic [15:0] exp_q[$];
    bit          rdy_q[$];
    bit          zero_q[$];
    logic [5:0]  op_q[$];

    function automatic logic [15:0] v(input bit pe, io, mr, mw, irw, rd, m2r, rw, sa,
                                      input logic [1:0] sb, ao, ps, input bit ill);
        return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, ill};
    endfunction

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        bit ok;
        ok = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000)
          || (op == 6'b000100) || (op == 6'b000010);
`ifdef MC_CTRL_ADDI_EN
        ok = ok || (op == 6'b001000);
`endif
        return ok;
    endfunction

    task automatic chk_vec(input string tag, input logic [15:0] e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, e);
        end
    endtask

    task automatic chk_bit(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", tag, o, e);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic [15:0] e, input bit r, input bit z);
        op_q.push_back(op);
        exp_q.push_back(e);
        rdy_q.push_back(r);
        zero_q.push_back(z);
    endtask

    // fw = fetch wait cycles, mw = data-memory wait cycles, z = zero flag in BRANCH.
    task automatic build(input logic [5:0] op, input int fw, input int mw, input bit z);
        for (int i = 0; i < fw; i++)
            push(op, v(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b0, rnd());
        push(op, v(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, rnd());
        push(op, v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!is_legal(op)), rnd(), rnd());
        if (op == 6'b100011) begin
            push(op, v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rnd(), rnd());
            for (int i = 0; i < mw; i++)
                push(op, v(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, rnd());
            push(op, v(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, rnd());
            push(op, v(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), rnd(), rnd());
        end else if (op == 6'b101011) begin
            push(op, v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rnd(), rnd());
            for (int i = 0; i < mw; i++)
                push(op, v(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, rnd());
            push(op, v(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, rnd());
        end else if (op == 6'b000000) begin
            push(op, v(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), rnd(), rnd());
            push(op, v(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), rnd(), rnd());
        end else if (op == 6'b000100) begin
            push(op, v(z,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), rnd(), z);
        end else if (op == 6'b000010) begin
            push(op, v(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), rnd(), rnd());
        end
`ifdef MC_CTRL_ADDI_EN
        else if (op == 6'b001000) begin
            push(op, v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rnd(), rnd());
            push(op, v(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), rnd(), rnd());
        end
`endif
    endtask

    task automatic play(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            opcode    = op_q.pop_front();
            mem_ready = rdy_q.pop_front();
            zero      = zero_q.pop_front();
            run       = rnd();
            #1;
            chk_vec(tag, exp_q.pop_front());
            chk_bit({tag, "_timeout"}, mem_timeout, exp_to);
        end
    endtask

    task automatic play_all(input string tag);
        play(exp_q.size(), tag);
    endtask

    task automatic start_idle();
        @(negedge clk);
        run       = 1'b1;
        mem_ready = rnd();
        #1;
        chk_vec("idle_start", 16'h0000);
        chk_bit("idle_start_timeout", mem_timeout, exp_to);
    endtask

    initial begin
        logic [5:0] ops [8];
        int idx;
        logic [5:0] op;

        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000010, 6'b001000, 6'b111111, 6'b000000};

        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            chk_vec("reset_outs", 16'h0000);
            chk_bit("reset_timeout", mem_timeout, 1'b0);
        end
        checks++;
        assert (dbg_state === S_IDLE) else begin
            failures++;
            $error("FAIL reset_state obs=%0d exp=%0d", dbg_state, S_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_vec("idle_after_reset", 16'h0000);

        build(6'b000000, 0, 0, 1'b0); play_all("rtype");
        build(6'b100011, 0, 3, 1'b0); play_all("lw_wait3");
        build(6'b000100, 1, 0, 1'b1); play_all("beq_taken");
        build(6'b000100, 0, 0, 1'b0); play_all("beq_not_taken");
        build(6'b111111, 0, 0, 1'b0); play_all("illegal");
        build(6'b001000, 0, 0, 1'b0); play_all("addi");
        build(6'b000010, 2, 0, 1'b0); play_all("jump");
        build(6'b101011, 1, 2, 1'b0); play_all("sw_wait2");

        // Fetch never completes: watchdog fires after WAIT_MAX stalled cycles.
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            run = 1'b0; mem_ready = 1'b0; zero = rnd();
            #1;
            chk_vec("to_fetch_wait", v(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0));
            chk_bit("to_pending", mem_timeout, 1'b0);
        end
        exp_to = 1'b1;
        repeat (4) begin
            @(negedge clk);
            run = 1'b0; mem_ready = rnd();
            #1;
            chk_vec("to_idle", 16'h0000);
            chk_bit("to_sticky", mem_timeout, 1'b1);
        end
        start_idle();
        build(6'b101011, 0, 1, 1'b0); play_all("sw_after_timeout");

        // Asynchronous reset in the middle of a stalled store.
        build(6'b101011, 0, 3, 1'b0);
        play(4, "sw_pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        exp_to = 1'b0;
        chk_vec("async_reset_outs", 16'h0000);
        chk_bit("async_reset_mem_write", mem_write, 1'b0);
        chk_bit("async_reset_timeout", mem_timeout, 1'b0);
        exp_q.delete(); rdy_q.delete(); zero_q.delete(); op_q.delete();
        run = 1'b0;
        @(negedge clk); #1;
        chk_vec("in_reset", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_vec("reset_release", 16'h0000);
        repeat (3) begin
            @(negedge clk);
            mem_ready = rnd(); zero = rnd();
            #1;
            chk_vec("idle_no_run", 16'h0000);
        end
        start_idle();

        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 7);
            op  = (idx == 7) ? 6'($urandom) : ops[idx];
            build(op, $urandom_range(0, 3), $urandom_range(0, 3), rnd());
            play_all("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
